hex_word_ascii_streamer: RTL
============================

# hex_word_ascii_streamer

Sequential, parametrised successor to the combinational nibble-to-ASCII converters. It accepts a word of NIBBLES hex digits over a valid/ready handshake and emits the word as a stream of 7-bit ASCII characters, most significant nibble first, one character per accepted output beat. Each word selects upper- or lower-case letters. The block sits between a word-producing datapath and a character sink such as a UART transmitter or a debug console.

## Interface
- NIBBLES, 8: hex digits per word. Input width is 4*NIBBLES. Legal range is 1..16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a word is offered.
- in_ready  out  1  block can accept a word. High only in IDLE.
- in_data  in  4*NIBBLES  word to print. Bits [4*NIBBLES-1 -: 4] are printed first.
- in_lower  in  1  sampled with in_data. 1 prints 'a'..'f'; 0 prints 'A'..'F'.
- out_valid  out  1  out_char is valid.
- out_ready  in  1  sink accepts the current character.
- out_char  out  7  7-bit ASCII code.
- out_last  out  1  high with the final character of a word.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - PREFIX: emits '0' then 'x'. Present only with HEX_PREFIX_EN.
  - DIGITS: emits the NIBBLES characters.
- Load: when in_valid&&in_ready at an edge, in_data goes into a shift register, in_lower is latched, and the nibble counter is cleared. The next state is PREFIX if the macro is defined, otherwise DIGITS.
- Digit mapping: nibble 0..9 maps to 0x30+n. Nibble 10..15 maps to 0x41+(n-10), or to 0x61+(n-10) when the latched lower flag is set.
- Beat: a character is consumed on an edge with out_valid&&out_ready. The register then shifts left by 4 and the counter increments. The counter is $clog2(NIBBLES+1) bits wide and never wraps.
- Last character: out_last=1 together with out_valid on the last digit. Consuming it returns the block to IDLE.
- Hold: while out_valid&&!out_ready, out_char, out_last and all state are held unchanged. The character must not change or drop.
- Input ignore: in_valid outside IDLE is ignored. in_data and in_lower changes have no effect mid-word.
- Reset: rst has priority over everything, including a handshake in the same cycle.
  - After the reset edge: state=IDLE, in_ready=1, out_valid=0, out_char=7'h00, out_last=0, busy=0.
  - A partially sent word is discarded with no out_last.

## Timing
- Output characters are registered. out_valid rises on the edge after the input handshake, so first-character latency is 1 cycle.
- Throughput is one character per cycle while out_ready is held high.
- A word occupies NIBBLES+1 cycles from handshake to the next possible handshake, or NIBBLES+3 cycles with the prefix.
- in_ready depends combinationally only on state. It never depends on in_valid or out_ready.
- There is no back-to-back overlap. in_ready rises the cycle after out_last is consumed.

## Configuration
- HEX_PREFIX_EN defined: every word is preceded by '0' (0x30) then 'x' (0x78).
  - 'x' is always lower case, regardless of in_lower.
  - out_last is never asserted during the prefix.
- HEX_PREFIX_EN undefined: the PREFIX state and its logic are absent. Only digits are emitted.

## Structure
- Package hex_ascii_pkg holds:
  - the ASCII constants ASC_ZERO=7'h30, ASC_UPPER_A=7'h41, ASC_LOWER_A=7'h61, ASC_X=7'h78;
  - the state enum {IDLE, PREFIX, DIGITS};
  - the function nibble_to_ascii(nibble, lower).
- One sub-module, hex_nibble_ascii, is the combinational nibble-plus-case to 7-bit converter, instantiated once on the shift-register top nibble.

## Test plan
Tests use NIBBLES=4 unless stated.
1. in_data=16'h1A3F, in_lower=0, out_ready=1 -> out_char 0x31,0x41,0x33,0x46 on consecutive cycles; out_last only with 0x46; in_ready back high on the next cycle.
2. in_data=16'hBEEF, in_lower=1 -> 0x62,0x65,0x65,0x66. Repeat with in_lower=0 -> 0x42,0x45,0x45,0x46.
3. Backpressure: 16'h0009 with out_ready low for 3 cycles on each beat -> each character (0x30,0x30,0x30,0x39) held stable while stalled, and no character lost or duplicated.
4. Reset while the 2nd character (0x41) of 16'h1A3F is valid -> next cycle out_valid=0, out_char=0, in_ready=1. A new word 16'h0001 then streams 0x30,0x30,0x30,0x31 cleanly.
5. HEX_PREFIX_EN build with in_data=16'h00FF, in_lower=1 -> 0x30,0x78,0x30,0x30,0x66,0x66; out_last only with the final 0x66.
6. NIBBLES=1, all 16 values 0..F, in_lower=0 -> 0x30..0x39 then 0x41..0x46, each single beat with out_last=1, and exactly 2 cycles per word.

Source files
------------

// File: rtl/hex_ascii_pkg.sv
// Shared ASCII constants, FSM state encoding and the nibble-to-ASCII mapping
// used by the hex word streamer.
package hex_ascii_pkg;

  localparam logic [6:0] ASC_ZERO    = 7'h30;
  localparam logic [6:0] ASC_UPPER_A = 7'h41;
  localparam logic [6:0] ASC_LOWER_A = 7'h61;
  localparam logic [6:0] ASC_X       = 7'h78;

  typedef enum logic [1:0] {IDLE, PREFIX, DIGITS} state_e;

  function automatic logic [6:0] nibble_to_ascii(input logic [3:0] nib, input logic lower);
    logic [3:0] w_ofs;
    if (nib < 4'd10) begin
      return ASC_ZERO + {3'b000, nib};
    end
    w_ofs = nib - 4'd10;
    return (lower ? ASC_LOWER_A : ASC_UPPER_A) + {3'b000, w_ofs};
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational converter: one hex nibble plus a case flag to a 7-bit ASCII code.
module hex_nibble_ascii
  import hex_ascii_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_lower,
  output logic [6:0] o_char
);

  assign o_char = nibble_to_ascii(i_nibble, i_lower);

endmodule

// File: rtl/hex_word_ascii_streamer.sv
// Streams a NIBBLES-digit hex word as ASCII characters, MS nibble first.
// Defining HEX_PREFIX_EN prepends "0x" to every word.
module hex_word_ascii_streamer
  import hex_ascii_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  input  logic                 in_lower,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           out_char,
  output logic                 out_last,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

`ifdef HEX_PREFIX_EN
  localparam state_e LOAD_STATE = PREFIX;
`else
  localparam state_e LOAD_STATE = DIGITS;
`endif

  state_e          r_state, w_next;
  logic [W-1:0]    r_shift;
  logic            r_lower;
  logic [CW-1:0]   r_cnt;
  logic            w_load, w_beat, w_last_dig;
  logic [6:0]      w_dig;

  assign w_load     = in_valid && (r_state == IDLE);
  assign w_beat     = out_valid && out_ready;
  assign w_last_dig = (r_cnt == CW'(NIBBLES - 1));

  hex_nibble_ascii u_conv (
    .i_nibble (r_shift[W-1 -: 4]),
    .i_lower  (r_lower),
    .o_char   (w_dig)
  );

`ifdef HEX_PREFIX_EN
  // Selects which prefix character is on the output: 0 -> '0', 1 -> 'x'.
  logic r_pfx;

  always_ff @(posedge clk) begin
    if (rst || w_load)                          r_pfx <= 1'b0;
    else if (w_beat && (r_state == PREFIX))     r_pfx <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (in_valid) w_next = LOAD_STATE;
`ifdef HEX_PREFIX_EN
      PREFIX: if (out_ready && r_pfx) w_next = DIGITS;
`endif
      DIGITS: if (out_ready && w_last_dig) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counter runs up to NIBBLES on the final beat; it is cleared on the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_lower <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shift <= in_data;
      r_lower <= in_lower;
      r_cnt   <= '0;
    end else if (w_beat && (r_state == DIGITS)) begin
      r_shift <= r_shift << 4;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    out_char = 7'h00;
    case (r_state)
`ifdef HEX_PREFIX_EN
      PREFIX:  out_char = r_pfx ? ASC_X : ASC_ZERO;
`endif
      DIGITS:  out_char = w_dig;
      default: out_char = 7'h00;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state != IDLE);
  assign out_last  = (r_state == DIGITS) && w_last_dig;

endmodule
